// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback arbiter for the 32x32 register file write port
//
// Purpose:
//   Merges ALU results and load-return data into the single register file
//   write port. Each source has a DEPTH-entry FIFO. Loads win arbitration,
//   except when the ALU head has lost MAX_WAIT consecutive times. busy_mask
//   reports registers with a write queued or in the output stage.
//
// Ports:
//   clk, rst                         - clock (rising edge), synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data - ALU writeback request channel
//   mem_valid/mem_ready/mem_rd/mem_data - load writeback request channel
//   register_write_en/rd_address/register_write_data - registered write port
//   busy_mask                        - per-register pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        register_write_en,
  output logic [4:0]  rd_address,
  output logic [31:0] register_write_data,
  output logic [31:0] busy_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [2:0]  WAIT_LIM = 3'(MAX_WAIT);

  logic [4:0]  alu_rd_q   [DEPTH];
  logic [31:0] alu_data_q [DEPTH];
  logic [PW-1:0] alu_wp, alu_rp;
  logic [PW:0]   alu_cnt;

  logic [4:0]  mem_rd_q   [DEPTH];
  logic [31:0] mem_data_q [DEPTH];
  logic [PW-1:0] mem_wp, mem_rp;
  logic [PW:0]   mem_cnt;

  logic       out_src_mem;  // which queue owns the output-stage entry
  logic [2:0] wait_cnt;

  logic [31:0] alu_busy, mem_busy;
  logic alu_full, mem_full, alu_head, mem_head;
  logic alu_push, mem_push, sel_alu, sel_mem;

  // Per-queue masks cover the FIFO contents plus the output stage, so a
  // register stays owned by one queue until its write has actually left.
  always_comb begin
    alu_busy = '0;
    mem_busy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(alu_cnt)) alu_busy[alu_rd_q[alu_rp + PW'(k)]] = 1'b1;
      if (k < int'(mem_cnt)) mem_busy[mem_rd_q[mem_rp + PW'(k)]] = 1'b1;
    end
    if (register_write_en && !out_src_mem) alu_busy[rd_address] = 1'b1;
    if (register_write_en &&  out_src_mem) mem_busy[rd_address] = 1'b1;
  end

  assign busy_mask = (alu_busy | mem_busy) & ~32'h1;

  assign alu_full = (alu_cnt == FULL_CNT);
  assign mem_full = (mem_cnt == FULL_CNT);
  assign alu_head = (alu_cnt != '0);
  assign mem_head = (mem_cnt != '0);

  // Readiness looks only at registered occupancy, so a pop on the same edge
  // never makes room for a push.
  assign mem_ready = !rst && !mem_full && !(alu_busy[mem_rd] && mem_rd != 5'd0);
  // A same-cycle load to the same register takes precedence over the ALU.
  assign alu_ready = !rst && !alu_full && !(mem_busy[alu_rd] && alu_rd != 5'd0)
                     && !(mem_valid && mem_ready && mem_rd == alu_rd && alu_rd != 5'd0);

  // Writes to x0 complete the handshake but are never queued.
  assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);

  assign sel_mem = mem_head && !(alu_head && wait_cnt == WAIT_LIM);
  assign sel_alu = alu_head && !sel_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wp              <= '0;
      alu_rp              <= '0;
      alu_cnt             <= '0;
      mem_wp              <= '0;
      mem_rp              <= '0;
      mem_cnt             <= '0;
      out_src_mem         <= 1'b0;
      wait_cnt            <= '0;
      register_write_en   <= 1'b0;
      rd_address          <= '0;
      register_write_data <= '0;
    end else begin
      if (alu_push) begin
        alu_rd_q[alu_wp]   <= alu_rd;
        alu_data_q[alu_wp] <= alu_data;
        alu_wp             <= alu_wp + PW'(1);
      end
      if (mem_push) begin
        mem_rd_q[mem_wp]   <= mem_rd;
        mem_data_q[mem_wp] <= mem_data;
        mem_wp             <= mem_wp + PW'(1);
      end
      if (sel_alu) alu_rp <= alu_rp + PW'(1);
      if (sel_mem) mem_rp <= mem_rp + PW'(1);

      case ({alu_push, sel_alu})
        2'b10:   alu_cnt <= alu_cnt + 1'b1;
        2'b01:   alu_cnt <= alu_cnt - 1'b1;
        default: alu_cnt <= alu_cnt;
      endcase
      case ({mem_push, sel_mem})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase

      // Output stage: address/data hold when idle, only the enable drops.
      register_write_en <= sel_alu || sel_mem;
      if (sel_mem) begin
        rd_address          <= mem_rd_q[mem_rp];
        register_write_data <= mem_data_q[mem_rp];
        out_src_mem         <= 1'b1;
      end else if (sel_alu) begin
        rd_address          <= alu_rd_q[alu_rp];
        register_write_data <= alu_data_q[alu_rp];
        out_src_mem         <= 1'b0;
      end

      // Counts consecutive losses of a waiting ALU head, saturating.
      if (sel_alu || !alu_head) wait_cnt <= '0;
      else if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        register_write_en;
  logic [4:0]  rd_address;
  logic [31:0] register_write_data;
  logic [31:0] busy_mask;

  int checks = 0;
  int errors = 0;

  logic [4:0]  log_rd[$];
  logic [31:0] log_data[$];

  regfile_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .register_write_en(register_write_en), .rd_address(rd_address),
    .register_write_data(register_write_data), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  // Register-file model: records every committed write.
  always @(posedge clk) begin
    if (register_write_en) begin
      log_rd.push_back(rd_address);
      log_data.push_back(register_write_data);
    end
  end

  typedef struct {
    logic r; logic av; logic [4:0] ar; logic [31:0] ad;
    logic mv; logic [4:0] mr; logic [31:0] md;
    logic e_ar; logic e_mr; logic e_we; logic [4:0] e_rd; logic [31:0] e_data; logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(logic r, logic av, logic [4:0] ar, logic [31:0] ad,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic ea, logic em, logic ew, logic [4:0] erd,
                              logic [31:0] edt, logic [31:0] eb);
    vec_t v;
    v.r = r; v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.e_ar = ea; v.e_mr = em; v.e_we = ew; v.e_rd = erd; v.e_data = edt; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; returns handshakes taken.
  task automatic tick(output bit a_acc, output bit m_acc);
    #1;
    a_acc = alu_valid && alu_ready;
    m_acc = mem_valid && mem_ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  initial begin
    bit aa, ma, done;
    int mi, ai, start;
    int exp_rd[9];
    exp_rd = '{1, 2, 3, 4, 20, 5, 6, 7, 8};

    //             rst av ar   ad       mv mr  md      | ar mr we rd  data      busy
    tbl[0]  = mk(1, 1, 3,  32'h33,   0, 0,  0,        0, 0, 0, 0,  32'h0,    32'h0);
    tbl[1]  = mk(1, 1, 3,  32'h33,   0, 0,  0,        0, 0, 0, 0,  32'h0,    32'h0);
    tbl[2]  = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 0,  32'h0,    32'h0);
    tbl[3]  = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 0,  32'h0,    32'h0);
    tbl[4]  = mk(0, 1, 5,  32'h25,   0, 0,  0,        1, 1, 0, 0,  32'h0,    32'h0);
    tbl[5]  = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 0,  32'h0,    32'h20);
    tbl[6]  = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 1, 5,  32'h25,   32'h20);
    tbl[7]  = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 5,  32'h25,   32'h0);
    tbl[8]  = mk(0, 0, 0,  0,        1, 7,  32'h77,   1, 1, 0, 5,  32'h25,   32'h0);
    tbl[9]  = mk(0, 1, 7,  32'hA7,   0, 0,  0,        0, 1, 0, 5,  32'h25,   32'h80);
    tbl[10] = mk(0, 1, 7,  32'hA7,   0, 0,  0,        0, 1, 1, 7,  32'h77,   32'h80);
    tbl[11] = mk(0, 1, 7,  32'hA7,   0, 0,  0,        1, 1, 0, 7,  32'h77,   32'h0);
    tbl[12] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 7,  32'h77,   32'h80);
    tbl[13] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 1, 7,  32'hA7,   32'h80);
    tbl[14] = mk(0, 1, 9,  32'hB9,   1, 9,  32'h99,   0, 1, 0, 7,  32'hA7,   32'h0);
    tbl[15] = mk(0, 1, 9,  32'hB9,   0, 0,  0,        0, 1, 0, 7,  32'hA7,   32'h200);
    tbl[16] = mk(0, 1, 9,  32'hB9,   0, 0,  0,        0, 1, 1, 9,  32'h99,   32'h200);
    tbl[17] = mk(0, 1, 9,  32'hB9,   0, 0,  0,        1, 1, 0, 9,  32'h99,   32'h0);
    tbl[18] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 9,  32'h99,   32'h200);
    tbl[19] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 1, 9,  32'hB9,   32'h200);
    tbl[20] = mk(0, 1, 2,  32'h22,   1, 1,  32'h11,   1, 1, 0, 9,  32'hB9,   32'h0);
    tbl[21] = mk(0, 1, 4,  32'h24,   1, 3,  32'h13,   1, 1, 0, 9,  32'hB9,   32'h06);
    tbl[22] = mk(0, 1, 6,  32'h26,   0, 0,  0,        0, 1, 1, 1,  32'h11,   32'h1E);
    tbl[23] = mk(0, 1, 6,  32'h26,   0, 0,  0,        0, 1, 1, 3,  32'h13,   32'h1C);
    tbl[24] = mk(0, 1, 6,  32'h26,   0, 0,  0,        1, 1, 1, 2,  32'h22,   32'h14);
    tbl[25] = mk(0, 1, 0,  32'hDEAD, 0, 0,  0,        1, 1, 1, 4,  32'h24,   32'h50);
    tbl[26] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 1, 6,  32'h26,   32'h40);
    tbl[27] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 6,  32'h26,   32'h0);
    tbl[28] = mk(0, 0, 0,  0,        0, 0,  0,        1, 1, 0, 6,  32'h26,   32'h0);

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 29; i++) begin
      rst = tbl[i].r;
      alu_valid = tbl[i].av; alu_rd = tbl[i].ar; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_rd = tbl[i].mr; mem_data = tbl[i].md;
      #1;
      chk($sformatf("row%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      chk($sformatf("row%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_mr));
      chk($sformatf("row%0d_we", i), 32'(register_write_en), 32'(tbl[i].e_we));
      chk($sformatf("row%0d_rd", i), 32'(rd_address), 32'(tbl[i].e_rd));
      chk($sformatf("row%0d_data", i), register_write_data, tbl[i].e_data);
      chk($sformatf("row%0d_busy", i), busy_mask, tbl[i].e_busy);
      @(posedge clk);
      @(negedge clk);
    end

    // Starvation guard: continuous loads rd 1..8 versus one ALU write to x20.
    start = log_rd.size();
    mi = 1;
    done = 1'b0;
    for (int c = 0; c < 40 && (mi <= 8 || !done); c++) begin
      mem_valid = (mi <= 8); mem_rd = (mi <= 8) ? 5'(mi) : 5'd0; mem_data = 32'h100 + 32'(mi);
      alu_valid = !done; alu_rd = 5'd20; alu_data = 32'h2020;
      tick(aa, ma);
      if (ma) mi++;
      if (aa) done = 1'b1;
    end
    chk("starve_all_accepted", 32'(done && mi == 9), 32'd1);
    idle_inputs();
    for (int c = 0; c < 8; c++) tick(aa, ma);
    chk("starve_write_count", 32'(log_rd.size() - start), 32'd9);
    for (int k = 0; k < 9; k++) begin
      if (start + k < log_rd.size()) begin
        chk($sformatf("starve_rd%0d", k), 32'(log_rd[start + k]), 32'(exp_rd[k]));
        chk($sformatf("starve_data%0d", k), log_data[start + k],
            (exp_rd[k] == 20) ? 32'h2020 : 32'h100 + 32'(exp_rd[k]));
      end
    end
    chk("starve_wait_cnt", 32'(dut.wait_cnt), 32'd0);

    // Reset while both queues and the output stage are busy.
    mi = 0; ai = 0;
    for (int c = 0; c < 4; c++) begin
      mem_valid = 1'b1; mem_rd = 5'(10 + mi); mem_data = 32'h500 + 32'(mi);
      alu_valid = 1'b1; alu_rd = 5'(24 + ai); alu_data = 32'h600 + 32'(ai);
      tick(aa, ma);
      if (ma) mi++;
      if (aa) ai++;
    end
    rst = 1'b1;
    #1;
    chk("rstmid_alu_ready", 32'(alu_ready), 32'd0);
    chk("rstmid_mem_ready", 32'(mem_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    start = log_rd.size();
    #1;
    chk("rstmid_we", 32'(register_write_en), 32'd0);
    chk("rstmid_busy", busy_mask, 32'd0);
    for (int c = 0; c < 6; c++) tick(aa, ma);
    chk("rstmid_no_writes", 32'(log_rd.size() - start), 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h1234;
    tick(aa, ma);
    chk("rstmid_new_accept", 32'(aa), 32'd1);
    idle_inputs();
    for (int c = 0; c < 3; c++) tick(aa, ma);
    chk("rstmid_new_count", 32'(log_rd.size() - start), 32'd1);
    if (log_rd.size() > start) begin
      chk("rstmid_new_rd", 32'(log_rd[start]), 32'd12);
      chk("rstmid_new_data", log_data[start], 32'h1234);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
